diff_out_lanes: RTL and testbench

//  Multi-lane, pipelined successor to the single-word differential output stage for the GBS20 PRBS7 path.

---
 rtl/diff_out_lanes.sv | 140 ++++++++++++++
 tb/tb_diff_out_lanes.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_out_lanes.sv
// Multi-lane complementary output stage for the PRBS7 path.
// Each lane word is selected from idle fill, training pattern or live data and then
// encoded into a p/n pair. Lane enable and polarity swap are applied in the same stage.
// The result is delayed by PIPE register stages in total.
// PIPE must lie in 1..4 and TRAIN_LEN must be at least 1.
module diff_out_lanes #(
  parameter int unsigned          WORDWIDTH = 16,
  parameter int unsigned          NLANES    = 4,
  parameter int unsigned          PIPE      = 1,
  parameter int unsigned          TRAIN_LEN = 64,
  parameter logic [WORDWIDTH-1:0] TRAIN_PAT = 16'hF0F0,
  parameter logic [WORDWIDTH-1:0] IDLE_PAT  = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NLANES*WORDWIDTH-1:0] sig_in,
  input  logic                        sig_valid,
  input  logic [NLANES-1:0]           lane_en,
  input  logic [NLANES-1:0]           polarity_swap,
  input  logic                        train_req,
  output logic                        train_busy,
  output logic                        out_valid,
  output logic [NLANES*WORDWIDTH-1:0] sig_out_p,
  output logic [NLANES*WORDWIDTH-1:0] sig_out_n
);

  localparam int unsigned CntW = $clog2(TRAIN_LEN + 1);
  localparam int unsigned BusW = NLANES * WORDWIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StTrain,
    StData
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Stage-1 encoded values, ahead of the first register.
  logic [BusW-1:0]      enc_p, enc_n;
  logic                 enc_vld;
  logic [WORDWIDTH-1:0] lane_word;

  // Output pipeline; index 0 is stage 1, index PIPE-1 drives the pins.
  logic [BusW-1:0] p_q [PIPE];
  logic [BusW-1:0] n_q [PIPE];
  logic [PIPE-1:0] vld_q;

  // State and training counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. Requests during a burst are ignored, so a burst is never extended.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (train_req) begin
          state_d = StTrain;
          cnt_d   = '0;
        end
      end
      StTrain: begin
        if (cnt_q == CntW'(TRAIN_LEN - 1)) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (train_req) begin
          state_d = StTrain;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Word select and p/n encode for every lane, using the state before the edge.
  always_comb begin
    enc_p     = '0;
    enc_n     = '0;
    lane_word = IDLE_PAT;
    enc_vld   = (state_q == StData) && sig_valid;
    for (int k = 0; k < int'(NLANES); k++) begin
      if (state_q == StTrain) begin
        lane_word = TRAIN_PAT;
      end else if (enc_vld) begin
        lane_word = sig_in[k*WORDWIDTH +: WORDWIDTH];
      end else begin
        lane_word = IDLE_PAT;
      end
      // A disabled lane stays 0/0, which makes it electrically idle.
      if (lane_en[k]) begin
        enc_p[k*WORDWIDTH +: WORDWIDTH] = polarity_swap[k] ? ~lane_word : lane_word;
        enc_n[k*WORDWIDTH +: WORDWIDTH] = polarity_swap[k] ? lane_word : ~lane_word;
      end
    end
  end

  // Stage-1 capture followed by PIPE-1 plain delay stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(PIPE); i++) begin
        p_q[i] <= '0;
        n_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      p_q[0]   <= enc_p;
      n_q[0]   <= enc_n;
      vld_q[0] <= enc_vld;
      for (int i = 1; i < int'(PIPE); i++) begin
        p_q[i]   <= p_q[i-1];
        n_q[i]   <= n_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign sig_out_p  = p_q[PIPE-1];
  assign sig_out_n  = n_q[PIPE-1];
  assign out_valid  = vld_q[PIPE-1];
  // This status comes straight from the state, so it leads the data by PIPE cycles.
  assign train_busy = (state_q == StTrain);

endmodule

// File: tb/tb_diff_out_lanes.sv
// Bench for diff_out_lanes: two instances (PIPE=1 and PIPE=3) share one stimulus stream.
// A mode/remaining-words model predicts stage-1 values and keeps a history of them.
// A negedge process compares both DUTs every cycle; directed steps pin literal values.
module tb_diff_out_lanes;

  localparam int unsigned       TL  = 64;
  localparam logic [15:0]       TP  = 16'hF0F0;
  localparam logic [15:0]       IP  = 16'h0000;
  localparam logic [63:0]       TP4 = {4{16'hF0F0}};

  logic        clk;
  logic        rstn;
  logic [63:0] sig_in;
  logic        sig_valid;
  logic [3:0]  lane_en;
  logic [3:0]  polarity_swap;
  logic        train_req;

  logic        busy1, busy3, ov1, ov3;
  logic [63:0] p1, n1, p3, n3;

  int n_cmp;
  int n_bad;

  diff_out_lanes #(.PIPE(1)) dut1 (
    .clk(clk), .rstn(rstn), .sig_in(sig_in), .sig_valid(sig_valid), .lane_en(lane_en),
    .polarity_swap(polarity_swap), .train_req(train_req), .train_busy(busy1),
    .out_valid(ov1), .sig_out_p(p1), .sig_out_n(n1)
  );

  diff_out_lanes #(.PIPE(3)) dut3 (
    .clk(clk), .rstn(rstn), .sig_in(sig_in), .sig_valid(sig_valid), .lane_en(lane_en),
    .polarity_swap(polarity_swap), .train_req(train_req), .train_busy(busy3),
    .out_valid(ov3), .sig_out_p(p3), .sig_out_n(n3)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the operating mode, the number of training words still owed,
  // and a history of the words that should appear (index d = d+1 cycles of latency).
  typedef enum logic [1:0] {MIdle, MTrain, MData} mode_e;
  mode_e       mode;
  int          left;
  logic [63:0] hp [5];
  logic [63:0] hn [5];
  logic        hv [5];

  logic [63:0] m_p, m_n;
  logic        m_v;
  logic [15:0] w;

  always_comb begin
    m_p = '0;
    m_n = '0;
    w   = IP;
    m_v = (mode == MData) && sig_valid;
    for (int k = 0; k < 4; k++) begin
      if (mode == MTrain)  w = TP;
      else if (m_v)        w = sig_in[k*16 +: 16];
      else                 w = IP;
      if (lane_en[k]) begin
        m_p[k*16 +: 16] = polarity_swap[k] ? ~w : w;
        m_n[k*16 +: 16] = polarity_swap[k] ? w : ~w;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode <= MIdle;
      left <= 0;
      for (int i = 0; i < 5; i++) begin
        hp[i] <= '0;
        hn[i] <= '0;
        hv[i] <= 1'b0;
      end
    end else begin
      hp[0] <= m_p;
      hn[0] <= m_n;
      hv[0] <= m_v;
      for (int i = 1; i < 5; i++) begin
        hp[i] <= hp[i-1];
        hn[i] <= hn[i-1];
        hv[i] <= hv[i-1];
      end
      if (mode == MTrain) begin
        left <= left - 1;
        if (left == 1) mode <= MData;
      end else if (train_req) begin
        mode <= MTrain;
        left <= TL;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("p_pipe1", p1, hp[0]);
    check("n_pipe1", n1, hn[0]);
    check("valid_pipe1", {63'd0, ov1}, {63'd0, hv[0]});
    check("busy_pipe1", {63'd0, busy1}, {63'd0, mode == MTrain});
    check("p_pipe3", p3, hp[2]);
    check("n_pipe3", n3, hn[2]);
    check("valid_pipe3", {63'd0, ov3}, {63'd0, hv[2]});
    check("busy_pipe3", {63'd0, busy3}, {63'd0, mode == MTrain});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int cnt_busy, cnt_tp1, cnt_tp3, cnt_ov;

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    clk           = 1'b0;
    rstn          = 1'b1;
    sig_in        = '0;
    sig_valid     = 1'b0;
    lane_en       = 4'h0;
    polarity_swap = 4'h0;
    train_req     = 1'b0;
    #1 rstn = 1'b0;
    step(3);
    rstn = 1'b1;

    // Idle after reset with lanes disabled: everything stays 0/0.
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("idle_p", p1 | p3, 64'd0);
      check("idle_n", n1 | n3, 64'd0);
      check("idle_busy_valid", {62'd0, busy1, ov3}, 64'd0);
    end

    // One training burst.
    lane_en   = 4'hF;
    train_req = 1'b1;
    step(1);
    train_req = 1'b0;
    check("busy_rises", {63'd0, busy1}, 64'd1);
    cnt_busy = 0; cnt_tp1 = 0; cnt_tp3 = 0; cnt_ov = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 1) begin
        check("train_p_first", p1, TP4);
        check("train_n_first", n1, ~TP4);
      end
      cnt_busy += int'(busy1);
      cnt_tp1  += int'(p1 == TP4 && n1 == ~TP4);
      cnt_tp3  += int'(p3 == TP4 && n3 == ~TP4);
      cnt_ov   += int'(ov1 | ov3);
      step(1);
    end
    check("burst_busy_cycles", 64'(cnt_busy), 64'(TL));
    check("burst_words_pipe1", 64'(cnt_tp1), 64'(TL));
    check("burst_words_pipe3", 64'(cnt_tp3), 64'(TL));
    check("burst_no_valid", 64'(cnt_ov), 64'd0);

    // Single valid word on lane 0, then the fill with the same latency.
    sig_in    = 64'h0000_0000_0000_1234;
    sig_valid = 1'b1;
    step(1);
    check("data_p_pipe1", {48'd0, p1[15:0]}, 64'h1234);
    check("data_valid_early", {63'd0, ov3}, 64'd0);
    step(2);
    check("data_p_pipe3", {48'd0, p3[15:0]}, 64'h1234);
    check("data_n_pipe3", {48'd0, n3[15:0]}, 64'hEDCB);
    check("data_valid_pipe3", {63'd0, ov3}, 64'd1);
    sig_valid = 1'b0;
    step(2);
    check("valid_holds", {63'd0, ov3}, 64'd1);
    step(1);
    check("fill_valid_pipe3", {63'd0, ov3}, 64'd0);
    check("fill_p_pipe3", {48'd0, p3[15:0]}, {48'd0, IP});
    check("fill_n_pipe3", {48'd0, n3[15:0]}, 64'hFFFF);

    // Mixed lane enables and polarity swaps.
    sig_in        = {4{16'h00FF}};
    sig_valid     = 1'b1;
    polarity_swap = 4'b0010;
    lane_en       = 4'b1011;
    step(3);
    check("lanes_p", p3, 64'h00FF_0000_FF00_00FF);
    check("lanes_n", n3, 64'hFF00_0000_00FF_FF00);

    // Retrain from data with a second request inside the burst.
    lane_en       = 4'hF;
    polarity_swap = 4'h0;
    sig_valid     = 1'b0;
    step(3);
    cnt_busy = 0; cnt_tp1 = 0;
    for (int i = 0; i < 150; i++) begin
      train_req = (i == 0 || i == 11);
      step(1);
      cnt_busy += int'(busy1);
      cnt_tp1  += int'(p1 == TP4);
    end
    train_req = 1'b0;
    check("retrain_busy_cycles", 64'(cnt_busy), 64'(TL));
    check("retrain_words", 64'(cnt_tp1), 64'(TL));
    sig_in    = {4{16'hABCD}};
    sig_valid = 1'b1;
    step(1);
    check("data_resumes", {63'd0, ov1}, 64'd1);
    check("data_resumes_p", p1, {4{16'hABCD}});

    // Asynchronous reset in the middle of a burst.
    sig_valid = 1'b0;
    train_req = 1'b1;
    step(1);
    train_req = 1'b0;
    step(30);
    rstn = 1'b0;
    #1;
    check("rst_busy", {62'd0, busy1, busy3}, 64'd0);
    check("rst_p", p1 | p3, 64'd0);
    check("rst_n", n1 | n3, 64'd0);
    step(1);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("post_rst_busy", {63'd0, busy1}, 64'd0);
      check("post_rst_p", p1, 64'd0);
    end

    // Randomised traffic with occasional training requests and resets.
    for (int i = 0; i < 3000; i++) begin
      sig_in        = {$urandom, $urandom};
      sig_valid     = ($urandom_range(0, 3) != 0);
      lane_en       = 4'($urandom);
      polarity_swap = 4'($urandom);
      train_req     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rstn = 1'b0;
        #2 rstn = 1'b1;
      end
      step(1);
    end

    train_req = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
